// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: combinational lookup, speculative history, resolve-time training/repair.
// Optional GSHARE_STATS_EN adds saturating branch and mispredict counters.
module gshare_predictor #(
   parameter int BHR_WIDTH       = 8,
   parameter int PHT_INDEX_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       lookup_valid,
   input  logic                       lookup_stall,
   input  logic [31:0]                lookup_pc,
   output logic                       pred_taken,
   output logic [PHT_INDEX_WIDTH-1:0] pred_index,
   output logic [BHR_WIDTH-1:0]       pred_bhr,
   output logic [1:0]                 pred_state,
   input  logic                       upd_valid,
   input  logic [PHT_INDEX_WIDTH-1:0] upd_index,
   input  logic [BHR_WIDTH-1:0]       upd_bhr,
   input  logic [1:0]                 upd_state,
   input  logic                       upd_taken,
   output logic                       upd_mispredict
`ifdef GSHARE_STATS_EN
   ,
   output logic [31:0]                stat_branches,
   output logic [31:0]                stat_mispredicts
`endif
);

   localparam int PHT_DEPTH = 1 << PHT_INDEX_WIDTH;

   logic [1:0]                 pht [PHT_DEPTH];
   logic [BHR_WIDTH-1:0]       spec_bhr;
   logic [PHT_INDEX_WIDTH-1:0] bhr_ext;
   logic [1:0]                 upd_cur;
   logic [1:0]                 upd_next;
   logic                       unused_pc_bits;

   // Only the word-aligned PC bits that fit the index take part in hashing.
   assign unused_pc_bits = ^{lookup_pc[31:PHT_INDEX_WIDTH+2], lookup_pc[1:0]};

   always_comb begin
      bhr_ext                 = '0;
      bhr_ext[BHR_WIDTH-1:0]  = spec_bhr;
   end

   assign pred_index     = lookup_pc[PHT_INDEX_WIDTH+1:2] ^ bhr_ext;
   assign pred_state     = pht[pred_index];
   assign pred_bhr       = spec_bhr;
   assign pred_taken     = pred_state[1];
   assign upd_mispredict = upd_valid & (upd_state[1] != upd_taken);

   // Training uses the live table entry; the carried state may be stale.
   always_comb begin
      upd_cur  = pht[upd_index];
      upd_next = upd_cur;
      if (upd_taken) begin
         if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
      end else begin
         if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
      end else if (upd_valid) begin
         pht[upd_index] <= upd_next;
      end
   end

   // Repair outranks the speculative shift issued in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         spec_bhr <= '0;
      end else if (upd_mispredict) begin
         spec_bhr <= {upd_bhr[BHR_WIDTH-2:0], upd_taken};
      end else if (lookup_valid && !lookup_stall) begin
         spec_bhr <= {spec_bhr[BHR_WIDTH-2:0], pred_taken};
      end
   end

`ifdef GSHARE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_valid && stat_branches != 32'hFFFF_FFFF)
            stat_branches <= stat_branches + 32'd1;
         if (upd_mispredict && stat_mispredicts != 32'hFFFF_FFFF)
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule
